// File: rtl/tag_rx_sched_if.sv
// Signal bundle between the tag RX burst scheduler, the configuration/statistics layer and the RX controller.
// Defining TAG_RX_SCHED_FIRSTPEAK_EN adds the first_peak_lat capture output.
interface tag_rx_sched_if #(
  parameter int CNT_WIDTH    = 32,
  parameter int NFRAME_WIDTH = 8,
  parameter int STAT_WIDTH   = 16
);
  logic                    enable;
  logic                    oneshot;
  logic [CNT_WIDTH-1:0]    search_len;
  logic [CNT_WIDTH-1:0]    guard_len;
  logic [NFRAME_WIDTH-1:0] nframes;
  logic                    clear_stats;
  logic [1:0]              rx_state;
  logic                    peak_detect_stb;
  logic                    run_rx;
  logic [2:0]              sched_state;
  logic [NFRAME_WIDTH-1:0] frame_count;
  logic                    lock_stb;
  logic                    burst_done_stb;
  logic                    timeout_stb;
  logic [STAT_WIDTH-1:0]   n_lock;
  logic [STAT_WIDTH-1:0]   n_timeout;
`ifdef TAG_RX_SCHED_FIRSTPEAK_EN
  logic [CNT_WIDTH-1:0]    first_peak_lat;
`endif

  // Configuration layer and controller side.
  modport master (
`ifdef TAG_RX_SCHED_FIRSTPEAK_EN
    input  first_peak_lat,
`endif
    output enable, oneshot, search_len, guard_len, nframes, clear_stats,
    output rx_state, peak_detect_stb,
    input  run_rx, sched_state, frame_count, lock_stb, burst_done_stb,
    input  timeout_stb, n_lock, n_timeout
  );

  // Scheduler side.
  modport slave (
`ifdef TAG_RX_SCHED_FIRSTPEAK_EN
    output first_peak_lat,
`endif
    input  enable, oneshot, search_len, guard_len, nframes, clear_stats,
    input  rx_state, peak_detect_stb,
    output run_rx, sched_state, frame_count, lock_stb, burst_done_stb,
    output timeout_stb, n_lock, n_timeout
  );
endinterface

// File: rtl/tag_rx_sched.sv
// Receive-window scheduler: arms the RX controller, bounds the preamble search, tracks N frames, then forces a guard gap.
// Optional TAG_RX_SCHED_FIRSTPEAK_EN builds the first-peak latency capture.
module tag_rx_sched #(
  parameter int CNT_WIDTH    = 32,
  parameter int NFRAME_WIDTH = 8,
  parameter int STAT_WIDTH   = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  tag_rx_sched_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_SEARCH = 3'd2,
    S_TRACK  = 3'd3,
    S_GUARD  = 3'd4
  } state_t;

  localparam logic [1:0] RX_INIT     = 2'b00;
  localparam logic [1:0] RX_LOC_SYNC = 2'b01;
  localparam logic [1:0] RX_LOC_RX   = 2'b11;

  localparam logic [CNT_WIDTH-1:0]    CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [NFRAME_WIDTH-1:0] FRAME_ONE = NFRAME_WIDTH'(1);
  localparam logic [STAT_WIDTH-1:0]   STAT_ONE  = STAT_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [1:0]              rst_sync_q;
  logic [1:0]              rx_state_q;
  logic                    oneshot_latch_q;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [NFRAME_WIDTH-1:0] frame_q, frame_d, frame_next;
  logic [STAT_WIDTH-1:0]   n_lock_q, n_lock_d;
  logic [STAT_WIDTH-1:0]   n_timeout_q, n_timeout_d;
  logic                    run_rx_q, run_rx_d;
  logic                    lock_stb_q, burst_done_stb_q, timeout_stb_q;
  logic                    ev_lock, ev_timeout, ev_burst, latch_set;
  logic                    search_expired, frame_done;
  logic [CNT_WIDTH-1:0]    guard_last;

  // Length inputs are compared live so a reprogrammed value applies on the next cycle.
  assign search_expired = (bus.search_len != '0) && (cnt_q == bus.search_len - CNT_ONE);
  assign guard_last     = (bus.guard_len == '0) ? '0 : bus.guard_len - CNT_ONE;
  assign frame_done     = (rx_state_q == RX_LOC_RX) && (bus.rx_state == RX_INIT);
  assign frame_next     = (frame_q == '1) ? frame_q : frame_q + FRAME_ONE;

  // The FSM may only leave IDLE once reset release has crossed two flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    ev_lock    = 1'b0;
    ev_timeout = 1'b0;
    ev_burst   = 1'b0;
    latch_set  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.enable && !oneshot_latch_q && rst_sync_q[1]) state_d = S_ARM;
      end
      S_ARM: begin
        cnt_d   = '0;
        frame_d = '0;
        state_d = bus.enable ? S_SEARCH : S_GUARD;
      end
      S_SEARCH: begin
        cnt_d = cnt_q + CNT_ONE;
        if (!bus.enable) begin
          state_d = S_GUARD;
        end else if (bus.rx_state == RX_LOC_SYNC) begin
          state_d = S_TRACK;
          ev_lock = 1'b1;
        end else if (search_expired) begin
          state_d    = S_GUARD;
          ev_timeout = 1'b1;
        end
      end
      S_TRACK: begin
        // Only consecutive INIT cycles count toward a lost-lock timeout.
        cnt_d = (bus.rx_state != RX_INIT) ? '0 : cnt_q + CNT_ONE;
        if (!bus.enable) begin
          state_d = S_GUARD;
        end else if (frame_done) begin
          frame_d = frame_next;
          if ((bus.nframes != '0) && (frame_next == bus.nframes)) begin
            state_d  = S_GUARD;
            ev_burst = 1'b1;
          end
        end else if ((bus.rx_state == RX_INIT) && search_expired) begin
          state_d    = S_GUARD;
          ev_timeout = 1'b1;
        end
      end
      S_GUARD: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q >= guard_last) begin
          if (bus.oneshot) begin
            latch_set = 1'b1;
            state_d   = S_IDLE;
          end else if (bus.enable) begin
            state_d = S_ARM;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d != state_q) && ((state_d == S_GUARD) || (state_d == S_TRACK))) cnt_d = '0;
  end

  always_comb begin
    run_rx_d    = (state_d == S_ARM) || (state_d == S_SEARCH) || (state_d == S_TRACK);
    n_lock_d    = n_lock_q;
    n_timeout_d = n_timeout_q;
    // A clear coincident with an increment leaves the counter at zero.
    if (bus.clear_stats) begin
      n_lock_d    = '0;
      n_timeout_d = '0;
    end else begin
      if (ev_lock && (n_lock_q != '1))       n_lock_d    = n_lock_q + STAT_ONE;
      if (ev_timeout && (n_timeout_q != '1)) n_timeout_d = n_timeout_q + STAT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state_q       <= '0;
      oneshot_latch_q  <= 1'b0;
      cnt_q            <= '0;
      frame_q          <= '0;
      n_lock_q         <= '0;
      n_timeout_q      <= '0;
      run_rx_q         <= 1'b0;
      lock_stb_q       <= 1'b0;
      burst_done_stb_q <= 1'b0;
      timeout_stb_q    <= 1'b0;
    end else begin
      rx_state_q       <= bus.rx_state;
      cnt_q            <= cnt_d;
      frame_q          <= frame_d;
      n_lock_q         <= n_lock_d;
      n_timeout_q      <= n_timeout_d;
      run_rx_q         <= run_rx_d;
      lock_stb_q       <= ev_lock;
      burst_done_stb_q <= ev_burst;
      timeout_stb_q    <= ev_timeout;
      if (!bus.enable)    oneshot_latch_q <= 1'b0;
      else if (latch_set) oneshot_latch_q <= 1'b1;
    end
  end

  assign bus.run_rx         = run_rx_q;
  assign bus.sched_state    = state_q;
  assign bus.frame_count    = frame_q;
  assign bus.lock_stb       = lock_stb_q;
  assign bus.burst_done_stb = burst_done_stb_q;
  assign bus.timeout_stb    = timeout_stb_q;
  assign bus.n_lock         = n_lock_q;
  assign bus.n_timeout      = n_timeout_q;

`ifdef TAG_RX_SCHED_FIRSTPEAK_EN
  logic [CNT_WIDTH-1:0] first_peak_q;
  logic                 peak_seen_q;

  // Latency of the first preamble peak within each search window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_peak_q <= '0;
      peak_seen_q  <= 1'b0;
    end else if (state_q == S_ARM) begin
      first_peak_q <= '0;
      peak_seen_q  <= 1'b0;
    end else if ((state_q == S_SEARCH) && bus.peak_detect_stb && !peak_seen_q) begin
      first_peak_q <= cnt_q;
      peak_seen_q  <= 1'b1;
    end
  end

  assign bus.first_peak_lat = first_peak_q;
`endif

endmodule

// File: tb/tb_tag_rx_sched.sv
// Directed bench for tag_rx_sched: a behavioural burst model is compared against the DUT every cycle,
// and hand-computed expectations pin the key latencies and counts.
module tb_tag_rx_sched;
  localparam int CW   = 32;
  localparam int NW   = 8;
  localparam int SW   = 8;
  localparam int SMAX = (1 << SW) - 1;
  localparam int FMAX = (1 << NW) - 1;

  localparam int ST_IDLE   = 0;
  localparam int ST_ARM    = 1;
  localparam int ST_SEARCH = 2;
  localparam int ST_TRACK  = 3;
  localparam int ST_GUARD  = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  tag_rx_sched_if #(.CNT_WIDTH(CW), .NFRAME_WIDTH(NW), .STAT_WIDTH(SW)) bus ();

  tag_rx_sched #(.CNT_WIDTH(CW), .NFRAME_WIDTH(NW), .STAT_WIDTH(SW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: tracks burst phase, elapsed search cycles, consecutive quiet cycles and guard time.
  int         m_state, m_age, m_quiet, m_guard_n, m_frames, m_nlock, m_ntmo, m_sync;
  bit         m_latch, m_lock_stb, m_tmo_stb, m_bd_stb;
  logic [1:0] m_prev_rx;

  task automatic model_reset();
    m_state = ST_IDLE; m_age = 0; m_quiet = 0; m_guard_n = 0; m_frames = 0;
    m_nlock = 0; m_ntmo = 0; m_sync = 0; m_latch = 0;
    m_lock_stb = 0; m_tmo_stb = 0; m_bd_stb = 0; m_prev_rx = 2'b00;
  endtask

  task automatic enter_guard();
    m_state   = ST_GUARD;
    m_guard_n = 0;
  endtask

  task automatic model_step();
    bit         en, lock, tmo, bd;
    logic [1:0] rx;
    int         slen, glen, nf;
    en = bus.enable; rx = bus.rx_state;
    slen = int'(bus.search_len); glen = int'(bus.guard_len); nf = int'(bus.nframes);
    lock = 0; tmo = 0; bd = 0;
    case (m_state)
      ST_IDLE: if (en && !m_latch && m_sync >= 2) m_state = ST_ARM;
      ST_ARM: begin
        m_frames = 0;
        m_age    = 0;
        if (!en) enter_guard(); else m_state = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (!en) enter_guard();
        else if (rx == 2'b01) begin
          m_state = ST_TRACK; lock = 1; m_quiet = 0;
        end else begin
          m_age++;
          if (slen != 0 && m_age == slen) begin enter_guard(); tmo = 1; end
        end
      end
      ST_TRACK: begin
        m_quiet = (rx == 2'b00) ? m_quiet + 1 : 0;
        if (!en) enter_guard();
        else if (m_prev_rx == 2'b11 && rx == 2'b00) begin
          if (m_frames < FMAX) m_frames++;
          if (nf != 0 && m_frames == nf) begin enter_guard(); bd = 1; end
        end else if (rx == 2'b00 && slen != 0 && m_quiet == slen) begin
          enter_guard(); tmo = 1;
        end
      end
      ST_GUARD: begin
        m_guard_n++;
        if (m_guard_n >= ((glen == 0) ? 1 : glen)) begin
          if (bus.oneshot) begin m_latch = 1; m_state = ST_IDLE; end
          else if (en) m_state = ST_ARM;
          else m_state = ST_IDLE;
        end
      end
      default: m_state = ST_IDLE;
    endcase
    if (!en) m_latch = 0;
    if (bus.clear_stats) begin
      m_nlock = 0; m_ntmo = 0;
    end else begin
      if (lock && m_nlock < SMAX) m_nlock++;
      if (tmo && m_ntmo < SMAX) m_ntmo++;
    end
    m_lock_stb = lock; m_tmo_stb = tmo; m_bd_stb = bd;
    if (m_sync < 2) m_sync++;
    m_prev_rx = rx;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Compare process: every output against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("cmp_sched_state", bus.sched_state, m_state);
      check("cmp_run_rx", bus.run_rx,
            (m_state == ST_ARM || m_state == ST_SEARCH || m_state == ST_TRACK) ? 1 : 0);
      check("cmp_frame_count", bus.frame_count, m_frames);
      check("cmp_lock_stb", bus.lock_stb, m_lock_stb);
      check("cmp_burst_done_stb", bus.burst_done_stb, m_bd_stb);
      check("cmp_timeout_stb", bus.timeout_stb, m_tmo_stb);
      check("cmp_n_lock", bus.n_lock, m_nlock);
      check("cmp_n_timeout", bus.n_timeout, m_ntmo);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got no end, expected end");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int st, input int budget, input string name);
    int n = 0;
    while (int'(bus.sched_state) != st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.sched_state, st);
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (bus.run_rx == 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    reset_n             = 1'b0;
    bus.enable          = 1'b1;
    bus.oneshot         = 1'b0;
    bus.search_len      = 100;
    bus.guard_len       = 8;
    bus.nframes         = 0;
    bus.clear_stats     = 1'b0;
    bus.rx_state        = 2'b00;
    bus.peak_detect_stb = 1'b0;
    tick(3);
    check("reset_sched_state", bus.sched_state, ST_IDLE);
    check("reset_run_rx", bus.run_rx, 0);
    check("reset_n_lock", bus.n_lock, 0);
    reset_n = 1'b1;

    // Lock ten cycles after ARM, one frame, then abort mid-TRACK.
    wait_state(ST_ARM, 10, "t1_arm");
    check("t1_run_rx_arm", bus.run_rx, 1);
    tick(9);
    bus.rx_state = 2'b01;
    tick(1);
    check("t1_track", bus.sched_state, ST_TRACK);
    check("t1_lock_stb", bus.lock_stb, 1);
    check("t1_n_lock", bus.n_lock, 1);
    bus.rx_state = 2'b11;
    tick(2);
    bus.rx_state = 2'b00;
    tick(1);
    check("t4_frame_count", bus.frame_count, 1);
    bus.rx_state = 2'b11;
    bus.enable   = 1'b0;
    tick(1);
    check("t4_abort_guard", bus.sched_state, ST_GUARD);
    check("t4_abort_run_rx", bus.run_rx, 0);
    check("t4_abort_no_tmo", bus.timeout_stb, 0);
    check("t4_abort_no_bd", bus.burst_done_stb, 0);
    check("t4_abort_n_lock", bus.n_lock, 1);
    check("t4_abort_n_timeout", bus.n_timeout, 0);
    check("t4_abort_frames", bus.frame_count, 1);
    bus.rx_state = 2'b00;
    wait_state(ST_IDLE, 20, "t4_idle");

    // Search timeout after 50 cycles, then an 8-cycle guard and re-arm.
    bus.search_len = 50;
    bus.enable     = 1'b1;
    wait_state(ST_SEARCH, 10, "t2_search");
    n = 0;
    while (bus.timeout_stb !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t2_timeout_latency", n, 50);
    check("t2_n_timeout", bus.n_timeout, 1);
    count_low(n);
    check("t2_guard_low_cycles", n, 8);
    check("t2_rearm", bus.sched_state, ST_ARM);
    bus.enable = 1'b0;
    wait_state(ST_IDLE, 20, "t2_idle");

    // Three-frame one-shot burst.
    bus.nframes    = 3;
    bus.oneshot    = 1'b1;
    bus.search_len = 0;
    bus.guard_len  = 4;
    bus.enable     = 1'b1;
    wait_state(ST_SEARCH, 10, "t3_search");
    bus.rx_state = 2'b01;
    tick(1);
    for (int k = 1; k <= 3; k++) begin
      bus.rx_state = 2'b11;
      tick(2);
      bus.rx_state = 2'b00;
      tick(1);
      check("t3_frame_count", bus.frame_count, k);
      check("t3_burst_done", bus.burst_done_stb, (k == 3) ? 1 : 0);
    end
    check("t3_guard", bus.sched_state, ST_GUARD);
    wait_state(ST_IDLE, 20, "t3_idle");
    tick(10);
    check("t3_oneshot_hold", bus.sched_state, ST_IDLE);
    check("t3_oneshot_run_rx", bus.run_rx, 0);
    bus.enable = 1'b0;
    tick(1);
    bus.enable  = 1'b1;
    bus.oneshot = 1'b0;
    tick(1);
    check("t3_retrigger_arm", bus.sched_state, ST_ARM);

    // Lock and timeout on the same SEARCH cycle: lock wins.
    bus.nframes    = 0;
    bus.search_len = 5;
    wait_state(ST_SEARCH, 10, "t5_search");
    tick(4);
    bus.rx_state = 2'b01;
    tick(1);
    check("t5_track", bus.sched_state, ST_TRACK);
    check("t5_lock_stb", bus.lock_stb, 1);
    check("t5_no_tmo", bus.timeout_stb, 0);
    check("t5_n_lock", bus.n_lock, 3);
    check("t5_n_timeout", bus.n_timeout, 1);

    // Drive repeated timeouts up to saturation, then one more.
    bus.rx_state   = 2'b00;
    bus.search_len = 2;
    bus.guard_len  = 1;
    n = 0;
    while (int'(bus.n_timeout) != SMAX && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t5_n_timeout_full", bus.n_timeout, 8'hFF);
    tick(1);
    n = 0;
    while (bus.timeout_stb !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_extra_timeout_seen", bus.timeout_stb, 1);
    check("t5_n_timeout_sat", bus.n_timeout, 8'hFF);

    // Clear coincident with a timeout increment; zero guard length.
    wait_state(ST_SEARCH, 10, "t5_clr_search");
    tick(1);
    bus.clear_stats = 1'b1;
    bus.guard_len   = 0;
    tick(1);
    bus.clear_stats = 1'b0;
    check("t5_clr_tmo_stb", bus.timeout_stb, 1);
    check("t5_clr_n_timeout", bus.n_timeout, 0);
    check("t5_clr_n_lock", bus.n_lock, 0);
    count_low(n);
    check("t6_guard0_low_cycles", n, 1);
    check("t6_guard0_arm", bus.sched_state, ST_ARM);

    // Asynchronous reset in the middle of TRACK.
    bus.search_len = 0;
    wait_state(ST_SEARCH, 10, "t6_search");
    bus.rx_state = 2'b01;
    tick(1);
    check("t6_track", bus.sched_state, ST_TRACK);
    bus.rx_state = 2'b11;
    tick(1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_run_rx", bus.run_rx, 0);
    check("t6_rst_state", bus.sched_state, ST_IDLE);
    check("t6_rst_n_lock", bus.n_lock, 0);
    check("t6_rst_lock_stb", bus.lock_stb, 0);
    check("t6_rst_frames", bus.frame_count, 0);
    tick(2);
    bus.rx_state = 2'b00;
    reset_n      = 1'b1;
    tick(2);
    check("t6_sync_hold", bus.sched_state, ST_IDLE);
    tick(1);
    check("t6_sync_arm", bus.sched_state, ST_ARM);

    bus.enable = 1'b0;
    wait_state(ST_IDLE, 30, "end_idle");
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tag_rx_sched.md
# tag_rx_sched

Receive-window scheduler for the tag RX controller. Sequences the controller's `run_rx` enable into bursts: arm, search for a preamble within a bounded window, track a programmed number of localization frames, then force a guard interval with the receiver held in clear. Sits between the GPIO/register configuration layer and the tag RX control block. Consumes that block's `rx_state` and `peak_detect_stb` debug outputs and returns lock and timeout statistics.

## Interface
Parameters:
- `CNT_WIDTH`, 32, width of the search and guard cycle counters and their length inputs.
- `NFRAME_WIDTH`, 8, width of the frames-per-burst setting and the frame counter.
- `STAT_WIDTH`, 16, width of the saturating statistics counters.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  scheduler enable (level).
- `oneshot`  in  1  run a single burst, then hold in IDLE until `enable` falls and rises again.
- `search_len`  in  CNT_WIDTH  search/no-activity timeout in cycles; 0 means no timeout.
- `guard_len`  in  CNT_WIDTH  receiver-off cycles between bursts; 0 is treated as 1.
- `nframes`  in  NFRAME_WIDTH  frames per burst; 0 means unlimited.
- `clear_stats`  in  1  synchronous clear of `n_lock` and `n_timeout`.
- `rx_state`  in  2  controller state: 00 INIT, 01 LOC_SYNC, 10 RX_START, 11 LOC_RX.
- `peak_detect_stb`  in  1  preamble peak strobe from the controller.
- `run_rx`  out  1  registered enable to the controller.
- `sched_state`  out  3  current state encoding.
- `frame_count`  out  NFRAME_WIDTH  frames completed in the current burst.
- `lock_stb`  out  1  one-cycle pulse on SEARCH→TRACK.
- `burst_done_stb`  out  1  one-cycle pulse when `nframes` frames complete.
- `timeout_stb`  out  1  one-cycle pulse on a search or track timeout.
- `n_lock`  out  STAT_WIDTH  saturating count of locks.
- `n_timeout`  out  STAT_WIDTH  saturating count of timeouts.

## Operation

State encodings: IDLE=0, ARM=1, SEARCH=2, TRACK=3, GUARD=4.

- **IDLE**
  - `run_rx`=0.
  - Go to ARM when `enable`=1 and the one-shot latch is clear.
  - The one-shot latch clears whenever `enable`=0.
- **ARM**
  - `run_rx`=1.
  - Clear the cycle counter and `frame_count`.
  - Go to SEARCH the next cycle.
- **SEARCH**
  - `run_rx`=1; the cycle counter increments each cycle.
  - If `rx_state`==01: go to TRACK, pulse `lock_stb`, increment `n_lock`.
  - Otherwise, if `search_len`≠0 and the counter equals `search_len`-1: go to GUARD, pulse `timeout_stb`, increment `n_timeout`.
  - Lock wins over a timeout on the same cycle.
- **TRACK**
  - `run_rx`=1.
  - A frame completes on a registered `rx_state` transition 11→00. On it, increment `frame_count`.
    - If `nframes`≠0 and the new count equals `nframes`: go to GUARD and pulse `burst_done_stb`.
  - The cycle counter resets whenever `rx_state`≠00. While `rx_state`==00 it counts.
    - Reaching `search_len`-1 (with `search_len`≠0) is a lost-lock timeout: go to GUARD, pulse `timeout_stb`, increment `n_timeout`.
  - Frame completion wins over a timeout on the same cycle.
- **GUARD**
  - `run_rx`=0; count max(`guard_len`,1) cycles.
  - On expiry:
    - If `oneshot`=1: set the one-shot latch and go to IDLE.
    - Otherwise, if `enable`=1: go to ARM.
    - Otherwise: go to IDLE.
- **Abort**
  - `enable`=0 in ARM, SEARCH or TRACK goes to GUARD the next cycle.
  - No strobe and no statistics update.
- **Statistics**
  - `n_lock` and `n_timeout` saturate at all-ones.
  - `clear_stats` zeroes both. If a clear and an increment coincide, the counter ends at 0.
- `frame_count` saturates at all-ones when `nframes`=0.
- `peak_detect_stb` is sampled only by the optional first-peak capture (see Configuration).
- Length inputs are sampled live. Changing them mid-state takes effect on the next comparison.

## Timing
- All outputs are registered.
- Reset value of every output is 0: `sched_state`=IDLE, `run_rx`=0, counters 0, strobes 0.
- `run_rx` rises 1 cycle after IDLE samples `enable`=1, i.e. the cycle ARM is registered.
- `run_rx` falls on the cycle GUARD is registered.
- `lock_stb` is asserted in the first TRACK cycle, 1 cycle after `rx_state`==01 is sampled.
- `burst_done_stb` and `timeout_stb` are asserted in the first GUARD cycle.
- A GUARD of length N holds `run_rx` low for exactly N cycles, then ARM follows.
- Minimum `run_rx`-low gap between bursts is 1 cycle.
- Asserting `reset_n` low mid-burst drops `run_rx` immediately (asynchronously) and clears all state and counters.
- Reset deassertion is synchronized internally with a 2-flop synchronizer before the state machine leaves IDLE.

## Configuration
- `TAG_RX_SCHED_FIRSTPEAK_EN` defined:
  - Adds output `first_peak_lat` (CNT_WIDTH).
  - Holds the cycle-counter value at the first `peak_detect_stb` of each SEARCH period.
  - Cleared in ARM; holds its value otherwise.
- Undefined:
  - The port is absent and no capture logic is built.
  - All other behaviour is identical.

## Test plan
- Reset with `enable`=1, `search_len`=100, `rx_state`=01 at cycle 10 after ARM → `lock_stb` at cycle 11, `n_lock`=1, `run_rx`=1 continuously.
- `search_len`=50, `rx_state` held 00 → `timeout_stb` exactly 50 cycles after SEARCH entry, `run_rx` low for `guard_len`=8 cycles, ARM again, `n_timeout`=1.
- `nframes`=3, drive three 11→00 transitions after lock → `frame_count`=3, `burst_done_stb` once, GUARD entered; with `oneshot`=1, remains IDLE until `enable` toggles 0→1.
- `enable` dropped during TRACK with `frame_count`=1 → GUARD next cycle, no strobes, statistics unchanged.
- Lock and timeout on the same SEARCH cycle → TRACK, `n_lock`+1, `n_timeout` unchanged; `n_timeout` forced to 0xFFFF plus one timeout stays 0xFFFF; `clear_stats` coincident with an increment → 0.
- `guard_len`=0 → `run_rx` low exactly 1 cycle; `reset_n` low mid-TRACK → `run_rx`=0 same cycle, all outputs 0.
